mtimer_multi: RTL and testbench

MTIMER_MULTI -- requirements
Module: mtimer_multi

---
 rtl/mtimer_pkg.sv | 21 ++
 rtl/mtimer_multi_if.sv | 15 +
 rtl/mtimer_cmp.sv | 38 +++
 rtl/mtimer_multi.sv | 112 +++++++++++
 tb/tb_mtimer_multi.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mtimer_pkg.sv
// Shared register map and CTRL field positions for the multi-compare timer.
package mtimer_pkg;

  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned DATA_W       = 32;

  localparam logic [ADDR_W-1:0] MTIME_LO = 6'd0;
  localparam logic [ADDR_W-1:0] MTIME_HI = 6'd1;
  localparam logic [ADDR_W-1:0] CTRL     = 6'd2;
  localparam logic [ADDR_W-1:0] PEND     = 6'd3;
  localparam logic [ADDR_W-1:0] CMP_BASE = 6'd8;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;

  // Word index of channel idx compare register, low (hi=0) or high (hi=1) half.
  function automatic logic [ADDR_W-1:0] cmp_addr(input int unsigned idx, input logic hi);
    return CMP_BASE + 6'(2 * idx) + {5'd0, hi};
  endfunction

endpackage

// File: rtl/mtimer_multi_if.sv
// Register-access bus and interrupt outputs of the multi-compare timer.
interface mtimer_multi_if #(
  parameter int unsigned NUM_CMP = 2
) ();
  logic               io_en;
  logic               io_we;
  logic [5:0]         io_addr;
  logic [31:0]        io_din;
  logic [31:0]        io_dout;
  logic [NUM_CMP-1:0] irq;
  logic               irq_any;

  modport master (output io_en, io_we, io_addr, io_din, input io_dout, irq, irq_any);
  modport slave  (input io_en, io_we, io_addr, io_din, output io_dout, irq, irq_any);
endinterface

// File: rtl/mtimer_cmp.sv
// One compare channel: CMP register with its write decode and registered irq.
module mtimer_cmp
  import mtimer_pkg::*;
#(
  parameter int unsigned CNT_W = 64,
  parameter int unsigned IDX   = 0
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              wr,
  input  logic [5:0]        addr,
  input  logic [31:0]       din,
  input  logic [CNT_W-1:0]  mtime,
  output logic [CNT_W-1:0]  cmp,
  output logic              irq
);

  logic [63:0] cmp64;
  assign cmp64 = 64'(cmp);

  // Compare register: each half written independently, bits above CNT_W dropped.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cmp <= '1;
    end else if (wr && addr == cmp_addr(IDX, 1'b0)) begin
      cmp <= CNT_W'({cmp64[63:32], din});
    end else if (wr && addr == cmp_addr(IDX, 1'b1)) begin
      cmp <= CNT_W'({din, cmp64[31:0]});
    end
  end

  // Interrupt level follows the registered mtime/cmp relation one cycle later.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) irq <= 1'b0;
    else         irq <= (mtime >= cmp);
  end

endmodule

// File: rtl/mtimer_multi.sv
// Machine timer with prescaler and NUM_CMP compare/interrupt channels.
module mtimer_multi
  import mtimer_pkg::*;
#(
  parameter int unsigned NUM_CMP = 2,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned PRE_W   = 8
) (
  input  logic          clk,
  input  logic          resetb,
  mtimer_multi_if.slave bus
);

  logic               wr;
  logic               rd;
  logic [CNT_W-1:0]   mtime;
  logic [63:0]        mt64;
  logic [PRE_W-1:0]   presc;
  logic [PRE_W-1:0]   div;
  logic               en;
  logic               tick;
  logic [31:0]        shadow;
  logic [31:0]        dout;
  logic [31:0]        rdata;
  logic [NUM_CMP-1:0] irq_r;
  logic [CNT_W-1:0]   cmp_val [NUM_CMP];

  assign wr   = bus.io_en & bus.io_we;
  assign rd   = bus.io_en & ~bus.io_we;
  assign mt64 = 64'(mtime);
  assign tick = en && (presc == div);

  // CTRL fields and prescaler; a CTRL write restarts the prescale period.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      en    <= 1'b1;
      div   <= '0;
      presc <= '0;
    end else if (wr && bus.io_addr == CTRL) begin
      en    <= bus.io_din[CTRL_EN_BIT];
      div   <= bus.io_din[CTRL_DIV_LSB +: PRE_W];
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + PRE_W'(1);
    end
  end

  // mtime counter; a software write to either half wins over the increment.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      mtime <= '0;
    end else if (wr && bus.io_addr == MTIME_LO) begin
      mtime <= CNT_W'({mt64[63:32], bus.io_din});
    end else if (wr && bus.io_addr == MTIME_HI) begin
      mtime <= CNT_W'({bus.io_din, mt64[31:0]});
    end else if (tick) begin
      mtime <= mtime + CNT_W'(1);
    end
  end

  // Compare channels.
  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    mtimer_cmp #(.CNT_W(CNT_W), .IDX(i)) u_cmp (
      .clk    (clk),
      .resetb (resetb),
      .wr     (wr),
      .addr   (bus.io_addr),
      .din    (bus.io_din),
      .mtime  (mtime),
      .cmp    (cmp_val[i]),
      .irq    (irq_r[i])
    );
  end

  // Read data select; unmapped words return zero.
  always_comb begin
    rdata = '0;
    case (bus.io_addr)
      MTIME_LO: rdata = mt64[31:0];
      MTIME_HI: rdata = shadow;
      CTRL: begin
        rdata[CTRL_EN_BIT]             = en;
        rdata[CTRL_DIV_LSB +: PRE_W]   = div;
      end
      PEND:     rdata[NUM_CMP-1:0] = irq_r;
      default: begin
        for (int i = 0; i < NUM_CMP; i++) begin
          if (bus.io_addr == cmp_addr(i, 1'b0)) rdata = 32'(cmp_val[i]);
          if (bus.io_addr == cmp_addr(i, 1'b1)) rdata = 32'(64'(cmp_val[i]) >> 32);
        end
      end
    endcase
  end

  // Registered read port; a MTIME_LO read latches the high word for a coherent pair.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dout   <= '0;
      shadow <= '0;
    end else if (rd) begin
      dout <= rdata;
      if (bus.io_addr == MTIME_LO) shadow <= mt64[63:32];
    end
  end

  assign bus.io_dout = dout;
  assign bus.irq     = irq_r;
  assign bus.irq_any = |irq_r;

endmodule

// File: tb/tb_mtimer_multi.sv
// Directed bench: a 64-bit two-channel timer and a 40-bit one-channel timer share stimulus.
module tb_mtimer_multi;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] rd0;
  logic [31:0] rd1;

  always #5 clk = ~clk;

  mtimer_multi_if #(.NUM_CMP(2)) bus0 ();
  mtimer_multi_if #(.NUM_CMP(1)) bus1 ();

  mtimer_multi #(.NUM_CMP(2), .CNT_W(64), .PRE_W(8)) dut0 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus0.slave)
  );

  mtimer_multi #(.NUM_CMP(1), .CNT_W(40), .PRE_W(8)) dut1 (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus1.slave)
  );

  task automatic bus_idle_drive();
    bus0.io_en = 1'b0; bus0.io_we = 1'b0; bus0.io_addr = '0; bus0.io_din = '0;
    bus1.io_en = 1'b0; bus1.io_we = 1'b0; bus1.io_addr = '0; bus1.io_din = '0;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus0.io_en = 1'b1; bus0.io_we = 1'b1; bus0.io_addr = a; bus0.io_din = d;
    bus1.io_en = 1'b1; bus1.io_we = 1'b1; bus1.io_addr = a; bus1.io_din = d;
    @(posedge clk); #1;
    bus_idle_drive();
  endtask

  task automatic bus_read(input logic [5:0] a);
    bus0.io_en = 1'b1; bus0.io_we = 1'b0; bus0.io_addr = a;
    bus1.io_en = 1'b1; bus1.io_we = 1'b0; bus1.io_addr = a;
    @(posedge clk); #1;
    bus_idle_drive();
    rd0 = bus0.io_dout;
    rd1 = bus1.io_dout;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus0.io_dout !== 32'h0) begin n_bad++; $display("FAIL reset_dout: got %h expected %h", bus0.io_dout, 32'h0); end
    n_cmp++; if (bus0.irq !== 2'b00) begin n_bad++; $display("FAIL reset_irq: got %b expected %b", bus0.irq, 2'b00); end
    n_cmp++; if (bus0.irq_any !== 1'b0) begin n_bad++; $display("FAIL reset_irq_any: got %b expected %b", bus0.irq_any, 1'b0); end
    @(negedge clk);
    resetb = 1'b1;
    idle(10);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd10) begin n_bad++; $display("FAIL idle_mtime_lo: got %0d expected %0d", rd0, 10); end
    bus_read(6'd8);
    n_cmp++; if (rd0 !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_cmp0_lo: got %h expected %h", rd0, 32'hFFFF_FFFF); end
    bus_read(6'd2);
    n_cmp++; if (rd0 !== 32'h1) begin n_bad++; $display("FAIL reset_ctrl: got %h expected %h", rd0, 32'h1); end
    bus_read(6'd3);
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL reset_pend: got %h expected %h", rd0, 32'h0); end
    bus_write(6'd5, 32'hDEAD_BEEF);
    bus_read(6'd5);
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL unmapped_word: got %h expected %h", rd0, 32'h0); end
  endtask

  task automatic test_wrap_coherent();
    bus_write(6'd1, 32'h0);
    bus_write(6'd0, 32'hFFFF_FFFE);
    idle(3);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'h1) begin n_bad++; $display("FAIL carry_lo: got %h expected %h", rd0, 32'h1); end
    bus_read(6'd1);
    n_cmp++; if (rd0 !== 32'h1) begin n_bad++; $display("FAIL carry_hi: got %h expected %h", rd0, 32'h1); end
    bus_write(6'd1, 32'h0);
    bus_write(6'd0, 32'hFFFF_FFFE);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL snap_lo: got %h expected %h", rd0, 32'hFFFF_FFFE); end
    idle(2);
    bus_read(6'd1);
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL snap_hi: got %h expected %h", rd0, 32'h0); end
  endtask

  task automatic test_prescale();
    bus_write(6'd2, 32'h0000_0301);
    bus_write(6'd1, 32'h0);
    bus_write(6'd0, 32'h0);
    idle(2);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd1) begin n_bad++; $display("FAIL div3_tick1: got %0d expected %0d", rd0, 1); end
    idle(3);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd2) begin n_bad++; $display("FAIL div3_tick2: got %0d expected %0d", rd0, 2); end
    idle(3);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd3) begin n_bad++; $display("FAIL div3_tick3: got %0d expected %0d", rd0, 3); end
    bus_write(6'd2, 32'h0000_0300);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd3) begin n_bad++; $display("FAIL freeze_start: got %0d expected %0d", rd0, 3); end
    idle(20);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd3) begin n_bad++; $display("FAIL freeze_end: got %0d expected %0d", rd0, 3); end
    bus_read(6'd2);
    n_cmp++; if (rd0 !== 32'h0000_0300) begin n_bad++; $display("FAIL ctrl_readback: got %h expected %h", rd0, 32'h0000_0300); end
    bus_write(6'd2, 32'h1);
  endtask

  task automatic test_write_tick();
    bus_write(6'd1, 32'h0);
    bus_write(6'd0, 32'h0000_1234);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'h0000_1234) begin n_bad++; $display("FAIL write_wins: got %h expected %h", rd0, 32'h0000_1234); end
  endtask

  task automatic test_compare();
    bus_write(6'd1, 32'h0);
    bus_write(6'd0, 32'd100);
    bus_write(6'd11, 32'h0);
    bus_write(6'd10, 32'd106);
    idle(4);
    n_cmp++; if (bus0.irq !== 2'b00) begin n_bad++; $display("FAIL cmp_early: got %b expected %b", bus0.irq, 2'b00); end
    idle(1);
    n_cmp++; if (bus0.irq !== 2'b10) begin n_bad++; $display("FAIL cmp_rise: got %b expected %b", bus0.irq, 2'b10); end
    n_cmp++; if (bus0.irq_any !== 1'b1) begin n_bad++; $display("FAIL cmp_any: got %b expected %b", bus0.irq_any, 1'b1); end
    bus_read(6'd3);
    n_cmp++; if (rd0 !== 32'h2) begin n_bad++; $display("FAIL pend: got %h expected %h", rd0, 32'h2); end
    bus_write(6'd10, 32'hFFFF_FFFF);
    bus_write(6'd11, 32'hFFFF_FFFF);
    idle(1);
    n_cmp++; if (bus0.irq !== 2'b00) begin n_bad++; $display("FAIL cmp_fall: got %b expected %b", bus0.irq, 2'b00); end
    n_cmp++; if (bus0.irq_any !== 1'b0) begin n_bad++; $display("FAIL cmp_fall_any: got %b expected %b", bus0.irq_any, 1'b0); end
  endtask

  task automatic test_cnt40();
    bus_write(6'd1, 32'hFFFF_FFFF);
    bus_read(6'd0);
    bus_read(6'd1);
    n_cmp++; if (rd1 !== 32'h0000_00FF) begin n_bad++; $display("FAIL w40_hi: got %h expected %h", rd1, 32'h0000_00FF); end
    bus_write(6'd0, 32'hFFFF_FFFE);
    idle(2);
    bus_read(6'd0);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL w40_wrap_lo: got %h expected %h", rd1, 32'h0); end
    bus_read(6'd1);
    n_cmp++; if (rd1 !== 32'h0) begin n_bad++; $display("FAIL w40_wrap_hi: got %h expected %h", rd1, 32'h0); end
  endtask

  task automatic test_reset_mid();
    bus0.io_en = 1'b1; bus0.io_we = 1'b1; bus0.io_addr = 6'd0; bus0.io_din = 32'h55;
    bus1.io_en = 1'b1; bus1.io_we = 1'b1; bus1.io_addr = 6'd0; bus1.io_din = 32'h55;
    #2;
    resetb = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus0.irq !== 2'b00) begin n_bad++; $display("FAIL mid_reset_irq: got %b expected %b", bus0.irq, 2'b00); end
    @(negedge clk);
    bus_idle_drive();
    resetb = 1'b1;
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'h0) begin n_bad++; $display("FAIL mid_reset_discard: got %h expected %h", rd0, 32'h0); end
    idle(1);
    bus_read(6'd0);
    n_cmp++; if (rd0 !== 32'd2) begin n_bad++; $display("FAIL mid_reset_count: got %0d expected %0d", rd0, 2); end
  endtask

  initial begin
    bus_idle_drive();
    test_reset();
    test_wrap_coherent();
    test_prescale();
    test_write_tick();
    test_compare();
    test_cnt40();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
